// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the CPU data-memory path: responder FSM encoding and
// the address fault conditions.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_e;

  localparam logic [1:0] WORD_ALIGNED = 2'b00;
  localparam int         WORD_LSB     = 2;

  // Misaligned byte offset or word index outside the populated array.
  function automatic logic is_fault(input logic [31:0] addr, input logic [31:0] depth_words);
    logic misaligned;
    logic out_of_range;
    misaligned   = (addr[1:0] != WORD_ALIGNED);
    out_of_range = ({2'b00, addr[31:WORD_LSB]} >= depth_words);
    return misaligned || out_of_range;
  endfunction

endpackage

// File: rtl/data_mem_responder_mem_word_array.sv
// 32-bit word storage: synchronous write, asynchronous read, no reset on contents.
module mem_word_array #(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder with programmable wait states and
// alignment/range fault reporting.
//
// state | meaning
// IDLE  | waiting for Req; latches the request on acceptance
// WAIT  | counting wait-state cycles, Req ignored
// RESP  | response edge: memory write, Ready/Err/DataOut registered, back to IDLE
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        Req,
  input  logic        WE,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic        Busy,
  output logic        Ready,
  output logic [31:0] DataOut,
  output logic        Err
);

  import data_mem_responder_pkg::*;

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  resp_state_e state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        fault;
  logic        mem_we;
  logic [31:0] rd_data;

  assign fault  = is_fault(addr_q, 32'(DEPTH_WORDS));
  // Clr gates the write so an abort on the response edge leaves memory untouched.
  assign mem_we = (state == RESP) && we_q && !fault && !Clr;

  mem_word_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk    (Clk),
    .we     (mem_we),
    .wr_idx (addr_q[IDX_W+1:2]),
    .wr_data(data_q),
    .rd_idx (addr_q[IDX_W+1:2]),
    .rd_data(rd_data)
  );

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      Busy    <= 1'b0;
      Ready   <= 1'b0;
      Err     <= 1'b0;
      DataOut <= 32'd0;
    end else begin
      Ready   <= 1'b0;
      Err     <= 1'b0;
      DataOut <= 32'd0;
      case (state)
        IDLE: begin
          Busy <= Req;
          if (Req) begin
            we_q   <= WE;
            addr_q <= Address;
            data_q <= DataIn;
            if (WAIT_CYCLES > 0) begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end else begin
              state <= RESP;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          Ready   <= 1'b1;
          Err     <= fault;
          DataOut <= (fault || we_q) ? 32'd0 : rd_data;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: table of single accesses on a 2-wait-state responder plus
// hand-written sequences for ignored requests, aborts and zero-wait streaming.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        clr;
  logic        req, we;
  logic [31:0] address, data_in;
  logic        busy, ready, err;
  logic [31:0] data_out;

  logic        req0, we0;
  logic [31:0] address0, data_in0;
  logic        busy0, ready0, err0;
  logic [31:0] data_out0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
    .Clk(clk), .Clr(clr), .Req(req), .WE(we), .Address(address), .DataIn(data_in),
    .Busy(busy), .Ready(ready), .DataOut(data_out), .Err(err)
  );

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .Clk(clk), .Clr(clr), .Req(req0), .WE(we0), .Address(address0), .DataIn(data_in0),
    .Busy(busy0), .Ready(ready0), .DataOut(data_out0), .Err(err0)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_err;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  // One access on the WAIT_CYCLES=2 instance; Ready must appear 3 edges after acceptance.
  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic e_err, input logic [31:0] e_dout, input string name);
    int lat;
    @(negedge clk);
    req = 1'b1; we = w; address = a; data_in = d;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk({name, " busy_accept"}, 32'(busy), 32'd1);
    chk({name, " ready_early"}, 32'(ready), 32'd0);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready) begin
        lat = k;
        break;
      end
    end
    chk({name, " latency"}, 32'(lat), 32'd3);
    chk({name, " err"}, 32'(err), 32'(e_err));
    chk({name, " dout"}, data_out, e_dout);
    chk({name, " busy_ready"}, 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk({name, " ready_pulse"}, 32'(ready), 32'd0);
    chk({name, " busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int readies;
    logic [31:0] wd;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 32'h0000_0012, 32'h0,         1'b1, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 32'h0000_0100, 32'h0BAD_0BAD, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1111_1111};
    vecs[6]  = '{1'b1, 32'h0000_00FC, 32'hA5A5_A5A5, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_00FC, 32'h0,         1'b0, 32'hA5A5_A5A5};
    vecs[8]  = '{1'b0, 32'h0000_0101, 32'h0,         1'b1, 32'h0};
    vecs[9]  = '{1'b1, 32'h0000_0003, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1111_1111};

    clr = 1'b1; req = 1'b0; we = 1'b0; address = '0; data_in = '0;
    req0 = 1'b0; we0 = 1'b0; address0 = '0; data_in0 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset ready", 32'(ready), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset dout", data_out, 32'd0);
    clr = 1'b0;

    for (int i = 0; i < 11; i++)
      do_access(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].exp_err, vecs[i].exp_dout,
                $sformatf("vec%0d", i));

    // Req pulse during WAIT must be dropped, not queued.
    @(negedge clk);
    req = 1'b1; we = 1'b1; address = 32'h20; data_in = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req = 1'b1; we = 1'b1; address = 32'h20; data_in = 32'h66;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    readies = 0;
    for (int k = 0; k < 8; k++) begin
      if (ready) readies++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("ignored_req ready_count", 32'(readies), 32'd1);
    do_access(1'b0, 32'h20, 32'h0, 1'b0, 32'h55, "after_ignored");

    // Abort a write in WAIT; the old contents must survive.
    do_access(1'b1, 32'h4, 32'hCAFE_F00D, 1'b0, 32'h0, "prior_write");
    @(negedge clk);
    req = 1'b1; we = 1'b1; address = 32'h4; data_in = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort ready", 32'(ready), 32'd0);
    chk("abort err", 32'(err), 32'd0);
    chk("abort dout", data_out, 32'd0);
    readies = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready) readies++;
    end
    chk("abort ready_count", 32'(readies), 32'd0);
    do_access(1'b0, 32'h4, 32'h0, 1'b0, 32'hCAFE_F00D, "after_abort");

    // Clr wins over a simultaneous Req.
    @(negedge clk);
    clr = 1'b1; req = 1'b1; we = 1'b1; address = 32'h0; data_in = 32'h999;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0; req = 1'b0;
    chk("clr_prio busy", 32'(busy), 32'd0);
    readies = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready) readies++;
    end
    chk("clr_prio ready_count", 32'(readies), 32'd0);
    do_access(1'b0, 32'h0, 32'h0, 1'b0, 32'h1111_1111, "after_clr_prio");

    // Zero wait states, Req held high: write/read pairs to 0x3C, Ready every other cycle.
    @(negedge clk);
    req0 = 1'b1; address0 = 32'h3C;
    for (int p = 0; p < 3; p++) begin
      wd = 32'h7700_0000 + 32'(p);
      we0 = 1'b1; data_in0 = wd;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("z%0d wr busy", p), 32'(busy0), 32'd1);
      chk($sformatf("z%0d wr gap", p), 32'(ready0), 32'd0);
      we0 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("z%0d wr ready", p), 32'(ready0), 32'd1);
      chk($sformatf("z%0d wr err", p), 32'(err0), 32'd0);
      chk($sformatf("z%0d wr dout", p), data_out0, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("z%0d rd gap", p), 32'(ready0), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("z%0d rd ready", p), 32'(ready0), 32'd1);
      chk($sformatf("z%0d rd dout", p), data_out0, wd);
    end
    req0 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("z idle busy", 32'(busy0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, number of 32-bit words stored (power of two, 2..1024).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, number of wait-state cycles inserted before each response (0..15).
REQ-003 SHALL have port Clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port Clr  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port Req  input  1  initiator request strobe; one-cycle pulse or held high.
REQ-006 SHALL have port WE  input  1  1 = write request, 0 = read request; sampled with Req.
REQ-007 SHALL have port Address  input  32  byte address; sampled with Req.
REQ-008 SHALL have port DataIn  input  32  write data; sampled with Req.
REQ-009 SHALL have port Busy  output  1  high from acceptance until the Ready cycle inclusive.
REQ-010 SHALL have port Ready  output  1  one-cycle response-valid pulse.
REQ-011 SHALL have port DataOut  output  32  read data, valid only while Ready=1 and WE was 0.
REQ-012 SHALL have port Err  output  1  access fault, valid only while Ready=1.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, WAIT and RESP.
REQ-014 SHALL, in IDLE with Req=1 at edge N, latch WE, Address and DataIn, then go to WAIT if WAIT_CYCLES>0, otherwise to RESP.
REQ-015 SHALL count WAIT_CYCLES cycles in WAIT, then enter RESP.
REQ-016 SHALL assert Ready during exactly one cycle, at edge N+WAIT_CYCLES+1, and return to IDLE at the following edge.
REQ-017 SHALL ignore Req while in WAIT or RESP, so no request is queued.
REQ-018 SHALL accept a new Req in IDLE on the edge right after RESP; back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
REQ-019 SHALL flag a fault when latched Address[1:0] is not 00 (misaligned).
REQ-020 SHALL flag a fault when the word index latched Address[31:2] is DEPTH_WORDS or greater (out of range).
REQ-021 SHALL, on a faulted access, drive Err=1 and DataOut=0 with Ready, and SHALL NOT modify memory.
REQ-022 SHALL, on a valid write, update memory at word index Address[31:2] on the Ready edge, with DataOut=0 and Err=0.
REQ-023 SHALL, on a valid read, drive DataOut with the stored word, with Err=0.
REQ-024 SHALL hold Busy, Ready, Err and DataOut at 0 whenever not in RESP, except Busy, which follows REQ-009.
REQ-025 SHALL return the new data on a read issued right after a write to the same address.

Reset
REQ-026 SHALL, with Clr=1 at an edge, force state IDLE, clear the wait counter and the latched request, and drive Busy=0, Ready=0, Err=0 and DataOut=0.
REQ-027 SHALL abort any in-flight access when Clr is asserted mid-operation: no Ready is produced and a pending write is not performed.
REQ-028 SHALL NOT initialise memory contents on reset; they are undefined until written.
REQ-029 SHALL have Clr take priority over a simultaneous Req.

Structure
REQ-030 SHALL place the FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2) and the fault-condition constants in a shared package used by the CPU memory-path blocks.
REQ-031 SHALL contain one sub-module, mem_word_array: a synchronous-write, asynchronous-read 32-bit x DEPTH_WORDS array with write enable, write index and read index.
REQ-032 SHALL keep the FSM, wait counter, address check and output registers in the top module.

Verification
REQ-033 SHALL cover: WAIT_CYCLES=2, write 0xDEADBEEF to 0x00000010 accepted at edge 5 -> Ready=1 only in the cycle after edge 8, Err=0, Busy high for cycles 5..8.
REQ-034 SHALL cover: read 0x00000010 after REQ-033 -> Ready after 3 cycles, DataOut=0xDEADBEEF, Err=0.
REQ-035 SHALL cover: read 0x00000012 -> Err=1, DataOut=0; write 0x00000100 with DEPTH_WORDS=64 -> Err=1, then a read of word 0 shows its value unchanged.
REQ-036 SHALL cover: a Req pulse during WAIT -> ignored, exactly one Ready, and the next IDLE Req is served normally.
REQ-037 SHALL cover: Clr asserted in WAIT of a write of 0x12345678 to 0x00000004 -> no Ready, all outputs 0, and a later read of 0x00000004 returns its prior value.
REQ-038 SHALL cover: WAIT_CYCLES=0 with Req held high -> Ready every second cycle, with alternating write then read of 0x0000003C returning the written value.
